// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit:
//   - lsu_state_e : FSM states of load_store_unit
//   - lsu_size_e  : access size after decode
//   - lsu_op_t    : decoded request (active / store / size / unsigned)
//   - BE_*        : unshifted byte-enable patterns
//   - BHW_* / BH_*: bit positions inside the one-hot type vectors
//                   ({byte, half, word} and {ubyte, uhalf})
//   - lsu_decode / lsu_be_base / lsu_is_misaligned : helper functions
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        WB    = 3'd5,
        ERR   = 3'd6
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic      active;       // at least one type bit was set
        logic      is_store;
        lsu_size_e size;
        logic      is_unsigned;
    } lsu_op_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // {byte, half, word}: byte is the MSB of the 3-bit vector
    localparam int BHW_B = 2;
    localparam int BHW_H = 1;
    localparam int BHW_W = 0;
    // {ubyte, uhalf}
    localparam int BH_B  = 1;
    localparam int BH_H  = 0;

    // Priority: store W > H > B > load W > H > ubyte > uhalf.
    function automatic lsu_op_t lsu_decode(input logic [2:0] store_bhw,
                                           input logic [2:0] load_bhw,
                                           input logic [1:0] uload_bh);
        lsu_op_t op;
        op.active      = 1'b1;
        op.is_store    = 1'b0;
        op.size        = SIZE_WORD;
        op.is_unsigned = 1'b0;
        if (store_bhw[BHW_W]) begin
            op.is_store = 1'b1;
            op.size     = SIZE_WORD;
        end else if (store_bhw[BHW_H]) begin
            op.is_store = 1'b1;
            op.size     = SIZE_HALF;
        end else if (store_bhw[BHW_B]) begin
            op.is_store = 1'b1;
            op.size     = SIZE_BYTE;
        end else if (load_bhw[BHW_W]) begin
            op.size = SIZE_WORD;
        end else if (load_bhw[BHW_H]) begin
            op.size = SIZE_HALF;
        end else if (load_bhw[BHW_B]) begin
            op.size = SIZE_BYTE;
        end else if (uload_bh[BH_B]) begin
            op.size        = SIZE_BYTE;
            op.is_unsigned = 1'b1;
        end else if (uload_bh[BH_H]) begin
            op.size        = SIZE_HALF;
            op.is_unsigned = 1'b1;
        end else begin
            op.active = 1'b0;
        end
        return op;
    endfunction

    function automatic logic [3:0] lsu_be_base(input lsu_size_e size);
        case (size)
            SIZE_BYTE: return BE_BYTE;
            SIZE_HALF: return BE_HALF;
            default:   return BE_WORD;
        endcase
    endfunction

    function automatic logic lsu_is_misaligned(input lsu_size_e size,
                                               input logic [1:0] offset);
        case (size)
            SIZE_HALF: return offset[0];
            SIZE_WORD: return |offset;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Purely combinational load data alignment: shifts the memory word right by
// 8*offset and sign- or zero-extends from bit 7 (byte) or bit 15 (half).
// The split path feeds an already merged word with offset 0.
// Ports:
//   rdata_i     : raw (or merged) read word
//   offset_i    : byte offset inside the word
//   size_i      : access size
//   unsigned_i  : 1 = zero-extend, 0 = sign-extend
//   result_o    : extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        shifted  = rdata_i >> {offset_i, 3'b000};
        result_o = shifted;
        case (size_i)
            SIZE_BYTE: result_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
            SIZE_HALF: result_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default:   result_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage: accepts one load or store per request, drives the
// data-memory bus (byte enables, lane-replicated store data) and returns a
// registered, aligned and extended load write-back.
//
// Configuration macro: LSU_MISALIGNED_SPLIT_EN
//   defined   : misaligned accesses are split into two aligned beats
//               (REQ/WAIT then REQ2/WAIT2); oMisaligned tied to 0.
//   undefined : misaligned accepts go to ERR, pulse oMisaligned for one
//               cycle, no bus request, no write-back.
//
// Ports:
//   iClk, iRstN                   clock, async active-low reset
//   iValid / oReady               request handshake (oReady only in IDLE)
//   iLoadTypeBHW, iULoadTypeBH,
//   iStoreTypeBHW                 one-hot access type vectors
//   iAddr, iStoreData, iRdAddr    address, store data, load destination
//   oMemReq..oMemWdata, iMemGnt   bus request, held until grant
//   iMemRvalid, iMemRdata         read response
//   oWbValid, oWbData, oWbRdAddr  registered write-back
//   oMisaligned                   one-cycle misaligned pulse
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // only 32 supported
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iValid,
    output logic              oReady,
    input  logic [2:0]        iLoadTypeBHW,
    input  logic [1:0]        iULoadTypeBH,
    input  logic [2:0]        iStoreTypeBHW,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iStoreData,
    input  logic [4:0]        iRdAddr,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [3:0]        oMemBe,
    output logic [DATA_W-1:0] oMemWdata,
    input  logic              iMemGnt,
    input  logic              iMemRvalid,
    input  logic [DATA_W-1:0] iMemRdata,
    output logic              oWbValid,
    output logic [DATA_W-1:0] oWbData,
    output logic [4:0]        oWbRdAddr,
    output logic              oMisaligned
);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    lsu_state_e  state_q, state_d;
    lsu_op_t     req_op;
    logic [1:0]  req_off;
    logic        req_mis;
    logic        accept;
    logic        start;
    logic [3:0]  be_first;
    logic [DATA_W-1:0] lanes;
    logic [DATA_W-1:0] wdata_new;

    assign req_op  = lsu_decode(iStoreTypeBHW, iLoadTypeBHW, iULoadTypeBH);
    assign req_off = iAddr[1:0];
    assign req_mis = lsu_is_misaligned(req_op.size, req_off);
    assign accept  = iValid & oReady;

    always_comb begin
        lanes = iStoreData;
        case (req_op.size)
            SIZE_BYTE: lanes = {4{iStoreData[7:0]}};
            SIZE_HALF: lanes = {2{iStoreData[15:0]}};
            default:   lanes = iStoreData;
        endcase
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [7:0]          be_wide;
    logic [3:0]          be_second;
    logic [2*DATA_W-1:0] lanes_rot;

    // Low nibble goes out on the first beat, high nibble on the second.
    assign be_wide   = {4'b0000, lsu_be_base(req_op.size)} << req_off;
    assign be_first  = be_wide[3:0];
    assign be_second = be_wide[7:4];
    // Rotating left by the offset puts each byte on its own lane for both
    // beats; for aligned accesses this leaves the replicated pattern intact.
    assign lanes_rot = {lanes, lanes} << {req_off, 3'b000};
    assign wdata_new = lanes_rot[2*DATA_W-1:DATA_W];
    assign start     = accept & req_op.active;
`else
    assign be_first  = lsu_be_base(req_op.size) << req_off;
    assign wdata_new = lanes;
    assign start     = accept & req_op.active & ~req_mis;
`endif

    // ------------------------------------------------------------------
    // Transaction registers
    // ------------------------------------------------------------------
    logic              is_store_q;
    lsu_size_e         size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [4:0]        wb_rd_q;
    logic              wb_load;
    logic [DATA_W-1:0] align_rdata;
    logic [1:0]        align_off;
    logic [DATA_W-1:0] align_result;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              split_q;
    logic [3:0]        be2_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [2*DATA_W-1:0] merged;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && req_op.active) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d = REQ;
`else
                    state_d = req_mis ? ERR : REQ;
`endif
                end
            end
            REQ: begin
                if (iMemGnt) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (is_store_q) state_d = split_q ? REQ2 : IDLE;
                    else            state_d = WAIT;
`else
                    state_d = is_store_q ? IDLE : WAIT;
`endif
                end
            end
            WAIT: begin
                if (iMemRvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d = split_q ? REQ2 : WB;
`else
                    state_d = WB;
`endif
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            REQ2: begin
                if (iMemGnt) state_d = is_store_q ? IDLE : WAIT2;
            end
            WAIT2: begin
                if (iMemRvalid) state_d = WB;
            end
`endif
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load alignment (shared by single-beat and merged paths)
    // ------------------------------------------------------------------
`ifdef LSU_MISALIGNED_SPLIT_EN
    // Second beat supplies the upper bytes; shift the 64-bit pair so the
    // accessed bytes land at bit 0, then extend with offset 0.
    assign merged = {iMemRdata, rdata0_q} >> {off_q, 3'b000};

    always_comb begin
        align_rdata = iMemRdata;
        align_off   = off_q;
        if (state_q == WAIT2) begin
            align_rdata = merged[DATA_W-1:0];
            align_off   = 2'b00;
        end
    end

    assign wb_load = iMemRvalid &
                     (((state_q == WAIT) & ~split_q) | (state_q == WAIT2));
`else
    assign align_rdata = iMemRdata;
    assign align_off   = off_q;
    assign wb_load     = iMemRvalid & (state_q == WAIT);
`endif

    lsu_load_align u_align (
        .rdata_i    (align_rdata),
        .offset_i   (align_off),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (align_result)
    );

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            is_store_q <= 1'b0;
            size_q     <= SIZE_BYTE;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q    <= 1'b0;
            be2_q      <= 4'b0000;
            rdata0_q   <= '0;
`endif
        end else begin
            if (start) begin
                is_store_q <= req_op.is_store;
                size_q     <= req_op.size;
                uns_q      <= req_op.is_unsigned;
                off_q      <= req_off;
                addr_q     <= {iAddr[ADDR_W-1:2], 2'b00};
                be_q       <= be_first;
                wdata_q    <= wdata_new;
                rd_q       <= iRdAddr;
`ifdef LSU_MISALIGNED_SPLIT_EN
                split_q    <= req_mis;
                be2_q      <= be_second;
`endif
            end
            if (wb_load) begin
                wb_data_q <= align_result;
                wb_rd_q   <= rd_q;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            if ((state_q == WAIT) && iMemRvalid) begin
                rdata0_q <= iMemRdata;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus signals are driven only while a request is pending
    // ------------------------------------------------------------------
    always_comb begin
        oMemReq   = 1'b0;
        oMemWe    = 1'b0;
        oMemAddr  = '0;
        oMemBe    = 4'b0000;
        oMemWdata = '0;
        if (state_q == REQ) begin
            oMemReq   = 1'b1;
            oMemWe    = is_store_q;
            oMemAddr  = addr_q;
            oMemBe    = be_q;
            oMemWdata = wdata_q;
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        else if (state_q == REQ2) begin
            oMemReq   = 1'b1;
            oMemWe    = is_store_q;
            oMemAddr  = addr_q + ADDR_W'(4);   // wraps modulo 2^ADDR_W
            oMemBe    = be2_q;
            oMemWdata = wdata_q;
        end
`endif
    end

    assign oReady    = (state_q == IDLE);
    assign oWbValid  = (state_q == WB);
    assign oWbData   = wb_data_q;
    assign oWbRdAddr = wb_rd_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign oMisaligned = 1'b0;
`else
    assign oMisaligned = (state_q == ERR);
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed self-checking bench for load_store_unit. Inputs are driven 1 time
// unit after the rising edge and outputs are sampled at the same point.
// Split-access scenarios are compiled when LSU_MISALIGNED_SPLIT_EN is defined.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iValid;
    logic        oReady;
    logic [2:0]  iLoadTypeBHW;
    logic [1:0]  iULoadTypeBH;
    logic [2:0]  iStoreTypeBHW;
    logic [31:0] iAddr;
    logic [31:0] iStoreData;
    logic [4:0]  iRdAddr;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [3:0]  oMemBe;
    logic [31:0] oMemWdata;
    logic        iMemGnt;
    logic        iMemRvalid;
    logic [31:0] iMemRdata;
    logic        oWbValid;
    logic [31:0] oWbData;
    logic [4:0]  oWbRdAddr;
    logic        oMisaligned;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .iClk          (iClk),
        .iRstN         (iRstN),
        .iValid        (iValid),
        .oReady        (oReady),
        .iLoadTypeBHW  (iLoadTypeBHW),
        .iULoadTypeBH  (iULoadTypeBH),
        .iStoreTypeBHW (iStoreTypeBHW),
        .iAddr         (iAddr),
        .iStoreData    (iStoreData),
        .iRdAddr       (iRdAddr),
        .oMemReq       (oMemReq),
        .oMemWe        (oMemWe),
        .oMemAddr      (oMemAddr),
        .oMemBe        (oMemBe),
        .oMemWdata     (oMemWdata),
        .iMemGnt       (iMemGnt),
        .iMemRvalid    (iMemRvalid),
        .iMemRdata     (iMemRdata),
        .oWbValid      (oWbValid),
        .oWbData       (oWbData),
        .oWbRdAddr     (oWbRdAddr),
        .oMisaligned   (oMisaligned)
    );

    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_inputs();
        iValid        = 1'b0;
        iLoadTypeBHW  = 3'b000;
        iULoadTypeBH  = 2'b00;
        iStoreTypeBHW = 3'b000;
        iAddr         = 32'h0;
        iStoreData    = 32'h0;
        iRdAddr       = 5'd0;
        iMemGnt       = 1'b0;
        iMemRvalid    = 1'b0;
        iMemRdata     = 32'h0;
    endtask

    // Present one request for a single cycle, then clear the request fields
    // so that any later bus value must come from the unit's own registers.
    task automatic issue(input logic [2:0] st, input logic [2:0] ld,
                         input logic [1:0] uld, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd);
        iValid        = 1'b1;
        iStoreTypeBHW = st;
        iLoadTypeBHW  = ld;
        iULoadTypeBH  = uld;
        iAddr         = addr;
        iStoreData    = data;
        iRdAddr       = rd;
        tick();
        iValid        = 1'b0;
        iStoreTypeBHW = 3'b000;
        iLoadTypeBHW  = 3'b000;
        iULoadTypeBH  = 2'b00;
        iAddr         = 32'h0;
        iStoreData    = 32'h0;
        iRdAddr       = 5'd0;
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_tests++;
        if (oReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", oReady);
        end
        n_tests++;
        if ({oMemReq, oMemWe, oMemAddr, oMemBe, oMemWdata, oWbValid, oWbData, oWbRdAddr, oMisaligned} !== 109'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h wbv=%b wbd=%h rd=%0d mis=%b want all 0",
                     oMemReq, oMemWe, oMemAddr, oMemBe, oMemWdata, oWbValid, oWbData, oWbRdAddr, oMisaligned);
        end
        iRstN = 1'b1;
        tick();
    endtask

    task automatic test_store_byte();
        issue(3'b100, 3'b000, 2'b00, 32'h0000_1003, 32'h0000_00AB, 5'd0);
        n_tests++;
        if ({oMemReq, oMemWe, oReady} !== 3'b110) begin
            n_fail++;
            $display("FAIL stb_req: got req/we/ready=%b want 110", {oMemReq, oMemWe, oReady});
        end
        n_tests++;
        if (oMemAddr !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL stb_addr: got %h want 00001000", oMemAddr);
        end
        n_tests++;
        if (oMemBe !== 4'b1000) begin
            n_fail++;
            $display("FAIL stb_be: got %b want 1000", oMemBe);
        end
        n_tests++;
        if (oMemWdata !== 32'hABAB_ABAB) begin
            n_fail++;
            $display("FAIL stb_wdata: got %h want abababab", oMemWdata);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        n_tests++;
        if ({oReady, oMemReq, oWbValid} !== 3'b100) begin
            n_fail++;
            $display("FAIL stb_done: got ready/req/wbv=%b want 100", {oReady, oMemReq, oWbValid});
        end
    endtask

    task automatic test_store_lanes();
        // Store half: replicated twice, aligned at offset 0.
        issue(3'b010, 3'b000, 2'b00, 32'h0000_0010, 32'h1234_CDEF, 5'd0);
        n_tests++;
        if ({oMemAddr, oMemBe, oMemWdata} !== {32'h0000_0010, 4'b0011, 32'hCDEF_CDEF}) begin
            n_fail++;
            $display("FAIL sth_lanes: got addr=%h be=%b wd=%h want 00000010 0011 cdefcdef", oMemAddr, oMemBe, oMemWdata);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        // All type bits set: store word wins.
        issue(3'b111, 3'b111, 2'b11, 32'h0000_0020, 32'hDEAD_BEEF, 5'd4);
        n_tests++;
        if ({oMemWe, oMemAddr, oMemBe, oMemWdata} !== {1'b1, 32'h0000_0020, 4'b1111, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL priority_stw: got we=%b addr=%h be=%b wd=%h want 1 00000020 1111 deadbeef", oMemWe, oMemAddr, oMemBe, oMemWdata);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        // ubyte beats uhalf when both unsigned bits are set.
        issue(3'b000, 3'b000, 2'b11, 32'h0000_0031, 32'h0, 5'd6);
        n_tests++;
        if ({oMemWe, oMemAddr, oMemBe} !== {1'b0, 32'h0000_0030, 4'b0010}) begin
            n_fail++;
            $display("FAIL priority_lbu_req: got we=%b addr=%h be=%b want 0 00000030 0010", oMemWe, oMemAddr, oMemBe);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h0000_9A00;
        tick();
        iMemRvalid = 1'b0;
        n_tests++;
        if ({oWbValid, oWbData, oWbRdAddr} !== {1'b1, 32'h0000_009A, 5'd6}) begin
            n_fail++;
            $display("FAIL priority_lbu_wb: got v=%b d=%h rd=%0d want 1 0000009a 6", oWbValid, oWbData, oWbRdAddr);
        end
        tick();
    endtask

    task automatic test_load_extend();
        // Signed byte load
        issue(3'b000, 3'b100, 2'b00, 32'h0000_2002, 32'h0, 5'd5);
        n_tests++;
        if ({oMemReq, oMemWe, oMemAddr, oMemBe} !== {1'b1, 1'b0, 32'h0000_2000, 4'b0100}) begin
            n_fail++;
            $display("FAIL lb_req: got req=%b we=%b addr=%h be=%b want 1 0 00002000 0100", oMemReq, oMemWe, oMemAddr, oMemBe);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h0080_0000;
        tick();
        iMemRvalid = 1'b0;
        iMemRdata  = 32'h0;
        n_tests++;
        if ({oWbValid, oWbData, oWbRdAddr, oReady} !== {1'b1, 32'hFFFF_FF80, 5'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL lb_wb: got v=%b d=%h rd=%0d ready=%b want 1 ffffff80 5 0", oWbValid, oWbData, oWbRdAddr, oReady);
        end
        tick();
        n_tests++;
        if ({oWbValid, oReady, oWbData, oWbRdAddr} !== {1'b0, 1'b1, 32'hFFFF_FF80, 5'd5}) begin
            n_fail++;
            $display("FAIL lb_hold: got v=%b ready=%b d=%h rd=%0d want 0 1 ffffff80 5", oWbValid, oReady, oWbData, oWbRdAddr);
        end
        // Stray rvalid while idle must not produce a write-back.
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h7777_7777;
        tick();
        iMemRvalid = 1'b0;
        n_tests++;
        if ({oWbValid, oReady, oWbData} !== {1'b0, 1'b1, 32'hFFFF_FF80}) begin
            n_fail++;
            $display("FAIL idle_rvalid: got v=%b ready=%b d=%h want 0 1 ffffff80", oWbValid, oReady, oWbData);
        end
        // Unsigned half load to x0
        issue(3'b000, 3'b000, 2'b01, 32'h0000_2002, 32'h0, 5'd0);
        n_tests++;
        if ({oMemAddr, oMemBe} !== {32'h0000_2000, 4'b1100}) begin
            n_fail++;
            $display("FAIL lhu_req: got addr=%h be=%b want 00002000 1100", oMemAddr, oMemBe);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h8001_0000;
        tick();
        iMemRvalid = 1'b0;
        n_tests++;
        if ({oWbValid, oWbData, oWbRdAddr} !== {1'b1, 32'h0000_8001, 5'd0}) begin
            n_fail++;
            $display("FAIL lhu_wb: got v=%b d=%h rd=%0d want 1 00008001 0", oWbValid, oWbData, oWbRdAddr);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [37:0] exp_req;
        exp_req = {1'b1, 1'b0, 32'h0000_4000, 4'b0011};
        issue(3'b000, 3'b010, 2'b00, 32'h0000_4000, 32'h0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({oMemReq, oMemWe, oMemAddr, oMemBe} !== exp_req) begin
                n_fail++;
                $display("FAIL stall_req[%0d]: got %h want %h", i, {oMemReq, oMemWe, oMemAddr, oMemBe}, exp_req);
            end
            tick();
        end
        iMemGnt = 1'b1;
        tick();
        // Grant held high in WAIT is ignored; rvalid delayed 4 cycles.
        iMemRdata = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({oMemReq, oWbValid, oReady} !== 3'b000) begin
                n_fail++;
                $display("FAIL stall_wait[%0d]: got req/wbv/ready=%b want 000", i, {oMemReq, oWbValid, oReady});
            end
            tick();
        end
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h1234_F00D;
        tick();
        iMemRvalid = 1'b0;
        n_tests++;
        if ({oWbValid, oWbData, oWbRdAddr} !== {1'b1, 32'hFFFF_F00D, 5'd7}) begin
            n_fail++;
            $display("FAIL stall_wb: got v=%b d=%h rd=%0d want 1 fffff00d 7", oWbValid, oWbData, oWbRdAddr);
        end
        tick();
        n_tests++;
        if ({oWbValid, oReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_pulse: got wbv/ready=%b want 01", {oWbValid, oReady});
        end
    endtask

    task automatic test_noop();
        issue(3'b000, 3'b000, 2'b00, 32'h0000_0044, 32'h0, 5'd1);
        n_tests++;
        if ({oReady, oMemReq, oMisaligned} !== 3'b100) begin
            n_fail++;
            $display("FAIL noop: got ready/req/mis=%b want 100", {oReady, oMemReq, oMisaligned});
        end
    endtask

`ifdef LSU_MISALIGNED_SPLIT_EN
    task automatic test_split_load();
        issue(3'b000, 3'b001, 2'b00, 32'h0000_3001, 32'h0, 5'd9);
        n_tests++;
        if ({oMemReq, oMemAddr, oMemBe, oMisaligned} !== {1'b1, 32'h0000_3000, 4'b1110, 1'b0}) begin
            n_fail++;
            $display("FAIL split_ld_b1: got req=%b addr=%h be=%b mis=%b want 1 00003000 1110 0", oMemReq, oMemAddr, oMemBe, oMisaligned);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h4433_2211;
        tick();
        iMemRvalid = 1'b0;
        n_tests++;
        if ({oMemReq, oMemAddr, oMemBe, oWbValid} !== {1'b1, 32'h0000_3004, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL split_ld_b2: got req=%b addr=%h be=%b wbv=%b want 1 00003004 0001 0", oMemReq, oMemAddr, oMemBe, oWbValid);
        end
        iMemGnt = 1'b1;
        tick();
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h0000_0055;
        tick();
        iMemRvalid = 1'b0;
        n_tests++;
        if ({oWbValid, oWbData, oWbRdAddr} !== {1'b1, 32'h5544_3322, 5'd9}) begin
            n_fail++;
            $display("FAIL split_ld_wb: got v=%b d=%h rd=%0d want 1 55443322 9", oWbValid, oWbData, oWbRdAddr);
        end
        tick();
    endtask

    task automatic test_split_wrap();
        issue(3'b010, 3'b000, 2'b00, 32'hFFFF_FFFF, 32'h0000_BEEF, 5'd0);
        n_tests++;
        if ({oMemWe, oMemAddr, oMemBe, oMemWdata} !== {1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hEFBE_EFBE}) begin
            n_fail++;
            $display("FAIL wrap_b1: got we=%b addr=%h be=%b wd=%h want 1 fffffffc 1000 efbeefbe", oMemWe, oMemAddr, oMemBe, oMemWdata);
        end
        iMemGnt = 1'b1;
        tick();
        n_tests++;
        if ({oMemReq, oMemWe, oMemAddr, oMemBe, oMemWdata} !== {1'b1, 1'b1, 32'h0000_0000, 4'b0001, 32'hEFBE_EFBE}) begin
            n_fail++;
            $display("FAIL wrap_b2: got req=%b we=%b addr=%h be=%b wd=%h want 1 1 00000000 0001 efbeefbe", oMemReq, oMemWe, oMemAddr, oMemBe, oMemWdata);
        end
        tick();
        iMemGnt = 1'b0;
        n_tests++;
        if ({oReady, oMemReq} !== 2'b10) begin
            n_fail++;
            $display("FAIL wrap_done: got ready/req=%b want 10", {oReady, oMemReq});
        end
    endtask
`else
    task automatic test_misaligned();
        issue(3'b000, 3'b001, 2'b00, 32'h0000_3001, 32'h0, 5'd9);
        n_tests++;
        if ({oMisaligned, oMemReq, oReady, oWbValid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mis_pulse: got mis/req/ready/wbv=%b want 1000", {oMisaligned, oMemReq, oReady, oWbValid});
        end
        tick();
        n_tests++;
        if ({oMisaligned, oMemReq, oReady, oWbValid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL mis_end: got mis/req/ready/wbv=%b want 0010", {oMisaligned, oMemReq, oReady, oWbValid});
        end
        // Half at odd address is misaligned too.
        issue(3'b010, 3'b000, 2'b00, 32'h0000_3003, 32'h0000_1111, 5'd0);
        n_tests++;
        if ({oMisaligned, oMemReq} !== 2'b10) begin
            n_fail++;
            $display("FAIL mis_half: got mis/req=%b want 10", {oMisaligned, oMemReq});
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        issue(3'b000, 3'b001, 2'b00, 32'h0000_5000, 32'h0, 5'd3);
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        iRstN   = 1'b0;
        #1;
        n_tests++;
        if ({oReady, oMemReq, oWbValid} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_mid_async: got ready/req/wbv=%b want 100", {oReady, oMemReq, oWbValid});
        end
        tick();
        iRstN      = 1'b1;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h1234_5678;
        tick();
        iMemRvalid = 1'b0;
        n_tests++;
        if ({oWbValid, oReady, oMemReq, oWbData} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_late: got wbv=%b ready=%b req=%b d=%h want 0 1 0 00000000", oWbValid, oReady, oMemReq, oWbData);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_lanes();
        test_load_extend();
        test_stall();
        test_noop();
`ifdef LSU_MISALIGNED_SPLIT_EN
        test_split_load();
        test_split_wrap();
`else
        test_misaligned();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
